// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader: sequencer states,
// Wishbone cycle-type / burst-type codes and the burst sizing helper.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    FINISH
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Beats in the next burst: whatever is left of the job, capped at the burst limit.
  function automatic logic [15:0] burst_len(input logic [15:0] remaining,
                                            input logic [15:0] max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Wishbone B4 read-side bus between the burst reader (master) and the RAM (slave).
interface ram_burst_reader_if;

  logic [29:0] cfu_ram_adr;
  logic [31:0] cfu_ram_dat_mosi;
  logic [3:0]  cfu_ram_sel;
  logic        cfu_ram_cyc;
  logic        cfu_ram_stb;
  logic        cfu_ram_we;
  logic [2:0]  cfu_ram_cti;
  logic [1:0]  cfu_ram_bte;
  logic [31:0] cfu_ram_dat_miso;
  logic        cfu_ram_ack;
  logic        cfu_ram_err;

  modport master (
    output cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc, cfu_ram_stb,
           cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
    input  cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
  );

  modport slave (
    input  cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc, cfu_ram_stb,
           cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
    output cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
  );

endinterface

// File: rtl/ram_burst_fifo.sv
// First-word-fall-through word FIFO that buffers burst data for the output stream.
// count reports occupancy so the reader can wait for room for a whole burst.
module ram_burst_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the array is not reset; empty/count already mark stale words invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads word_count words from a Wishbone RAM starting at start_addr using
// incrementing bursts of up to MAX_BURST beats, and streams them out through
// a FIFO. A burst is only issued once the FIFO has room for all of its beats.
// Build option RAM_BURST_READER_ERR_ABORT_EN: when defined a bus error aborts
// the job with a sticky err; otherwise the errored beat yields a zero word and
// err pulses for one cycle.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [29:0]        start_addr,
  input  logic [15:0]        word_count,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  ram_burst_reader_if.master wb
);

`ifdef RAM_BURST_READER_ERR_ABORT_EN
  localparam bit ERR_ABORT = 1'b1;
`else
  localparam bit ERR_ABORT = 1'b0;
`endif

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [29:0]   adr;
  logic [15:0]   remaining;
  logic [15:0]   beats;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          beat_taken;
  logic          bus_err;
  logic [31:0]   push_data;
  logic [15:0]   next_len;
  logic [15:0]   free_slots;

  assign wb.cfu_ram_adr      = adr;
  assign wb.cfu_ram_dat_mosi = '0;
  assign wb.cfu_ram_sel      = 4'b1111;
  assign wb.cfu_ram_cyc      = cyc;
  assign wb.cfu_ram_stb      = stb;
  assign wb.cfu_ram_we       = 1'b0;
  assign wb.cfu_ram_cti      = cti;
  assign wb.cfu_ram_bte      = BTE_LINEAR;

  assign next_len   = burst_len(remaining, 16'(MAX_BURST));
  assign free_slots = 16'(FIFO_DEPTH) - 16'(fifo_count);
  assign out_valid  = !fifo_empty;

  // Decide whether the current bus cycle completes a beat and what word it yields.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    beat_taken = 1'b0;
    push_data  = wb.cfu_ram_dat_miso;
    bus_err    = (state == BURST) && wb.cfu_ram_err;
    if (state == BURST) begin
      if (ERR_ABORT) begin
        beat_taken = wb.cfu_ram_ack && !wb.cfu_ram_err;
      end else begin
        beat_taken = wb.cfu_ram_ack || wb.cfu_ram_err;
        if (wb.cfu_ram_err) push_data = '0;
      end
    end
  end

  ram_burst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (beat_taken && !fifo_full),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Job sequencer: latches the job, paces bursts against FIFO room, drives the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      cti       <= CTI_CLASSIC;
      adr       <= '0;
      remaining <= '0;
      beats     <= '0;
    end else begin
      done <= 1'b0;
      if (!ERR_ABORT) err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            adr       <= start_addr;
            remaining <= word_count;
            busy      <= 1'b1;
            err       <= 1'b0;
            state     <= (word_count == '0) ? FINISH : WAIT_SPACE;
          end
        end

        WAIT_SPACE: begin
          if (free_slots >= next_len) begin
            cyc   <= 1'b1;
            stb   <= 1'b1;
            cti   <= (next_len == 16'd1) ? CTI_END : CTI_INCR;
            beats <= next_len;
            state <= BURST;
          end
        end

        BURST: begin
          if (ERR_ABORT && bus_err) begin
            // Abandon the rest of the job; the errored beat delivers nothing.
            cyc   <= 1'b0;
            stb   <= 1'b0;
            cti   <= CTI_CLASSIC;
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            if (bus_err) err <= 1'b1;
            if (beat_taken) begin
              adr       <= adr + 30'd1;
              remaining <= remaining - 16'd1;
              beats     <= beats - 16'd1;
              if (beats == 16'd1) begin
                cyc   <= 1'b0;
                stb   <= 1'b0;
                cti   <= CTI_CLASSIC;
                state <= (remaining == 16'd1) ? FINISH : WAIT_SPACE;
              end else if (beats == 16'd2) begin
                cti <= CTI_END;
              end
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO depth in 32-bit words (power of two, >= MAX_BURST).
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per Wishbone burst (1..FIFO_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  job request; sampled only when busy=0.
REQ-006 SHALL have port start_addr  input  30  first word address.
REQ-007 SHALL have port word_count  input  16  words to read.
REQ-008 SHALL have port busy  output  1  job in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-010 SHALL have port err  output  1  error status, meaning set by configuration.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32; valid/ready word stream.
REQ-012 SHALL have Wishbone master ports cfu_ram_adr o30, cfu_ram_dat_mosi o32, cfu_ram_sel o4, cfu_ram_cyc o1, cfu_ram_stb o1, cfu_ram_we o1, cfu_ram_cti o3, cfu_ram_bte o2, cfu_ram_dat_miso i32, cfu_ram_ack i1, cfu_ram_err i1.

Function
REQ-013 SHALL use FSM states IDLE, WAIT_SPACE, BURST, FINISH.
REQ-014 IDLE: start=1 latches address/count, sets busy=1; count 0 -> FINISH, else WAIT_SPACE.
REQ-015 WAIT_SPACE: compute len = min(MAX_BURST, remaining); enter BURST when FIFO free slots (depth - occupancy) >= len; no bus activity until then.
REQ-016 BURST: cyc=stb=1, we=0, sel=4'b1111, dat_mosi=0, bte=2'b00; cti=3'b010 except last beat 3'b111 (len=1 -> 3'b111).
REQ-017 Each ack SHALL push dat_miso into FIFO, increment adr by 1, decrement remaining and beat counter in same cycle.
REQ-018 After last beat ack: cyc/stb drop next cycle; remaining>0 -> WAIT_SPACE, else FINISH.
REQ-019 FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 FIFO overflow is impossible by REQ-015; push and pop in same cycle keep occupancy unchanged.
REQ-022 out_valid = FIFO non-empty; pop on out_valid & out_ready; out_data = FIFO head, first-word-fall-through.
REQ-023 FIFO contents SHALL persist after done until popped; a new job MAY start with data still queued.
REQ-024 Address SHALL wrap modulo 2^30 without fault.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, cyc=stb=0, cti=0, busy=done=err=0, FIFO empty (out_valid=0), adr=0.
REQ-026 Reset mid-burst SHALL abandon the burst; no ack after reset release is accepted until a new job.

Configuration
REQ-027 Macro RAM_BURST_READER_ERR_ABORT_EN:
  defined -> cfu_ram_err during BURST ends the burst, skips remaining words, goes to FINISH, sets err=1 (sticky until next accepted start); no push for the errored beat.
  undefined -> err beat treated as ack with data 32'h0 pushed, job continues; err=1 for one cycle per errored beat.

Structure
REQ-028 Package ram_burst_reader_pkg SHALL hold the FSM state enum and CTI constants (CLASSIC 3'b000, INCR 3'b010, END 3'b111).
REQ-029 FIFO SHALL be sub-module ram_burst_fifo (parameter DEPTH; push/pop/full/empty/count ports).

Verification
REQ-030 start_addr=0x100, word_count=3, ack every cycle, out_ready=1 -> one burst, adr 0x100..0x102, cti 010,010,111, three words out in order, done once.
REQ-031 word_count=10, MAX_BURST=4, out_ready=0 -> bursts of 4,4 then stall (free 0); set out_ready=1 -> final burst of 2; 10 words, done after 10th ack.
REQ-032 word_count=0 -> no cyc, done pulse 2 cycles after start, busy high 1 cycle.
REQ-033 err on beat 2 of 4: with macro -> burst ends, 1 word queued, err sticky, done; without -> 4 words, word 2 = 0, err pulse 1 cycle.
REQ-034 reset=0 mid-burst (beat 2 of 4) -> cyc=0 same cycle, out_valid=0, busy=0; new job after release runs normally.
